// File: rtl/uart_rx_buffered_if.sv
// Signal bundle for uart_rx_buffered: serial line and controls in, FIFO head out.
interface uart_rx_buffered_if #(
  parameter int N_BITS     = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                        rxd;
  logic                        enable;
  logic                        ready;
  logic                        err_clear;
  logic [N_BITS-1:0]           data;
  logic                        valid;
  logic                        parity_err;
  logic                        frame_err;
  logic                        overrun;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  modport master (
    output rxd, enable, ready, err_clear,
    input  data, valid, parity_err, frame_err, overrun, fifo_count
  );

  modport slave (
    input  rxd, enable, ready, err_clear,
    output data, valid, parity_err, frame_err, overrun, fifo_count
  );
endinterface

// File: rtl/uart_rx_buffered.sv
// UART receiver with 3-point majority bit sampling feeding a small word FIFO
// that carries per-word parity/framing flags and a sticky overrun flag.
module uart_rx_buffered #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int N_BITS     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  uart_rx_buffered_if.slave bus
);
  localparam int CLK_P_BIT = CLOCK_HZ / BAUD_RATE;
  localparam int HALF      = CLK_P_BIT / 2;
  localparam int CNT_W     = $clog2(CLK_P_BIT);
  localparam int IDX_W     = $clog2(N_BITS + 1);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int WORD_W    = N_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t             state_q, state_d;
  logic               rxd_p0, rxd_p1, rxd_d1, rxd_d2;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   bit_idx;
  logic [N_BITS-1:0]  shreg;
  logic               par_err_q, frm_err_q;
  logic               sample_bit, at_sample, at_wrap;
  logic               start_det, idx_clr, push;
  logic [WORD_W-1:0]  push_word, head;
  logic [WORD_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;
  logic               full, pop, wr_en, drop, overrun_q;

  // Stage p0/p1: two-flop synchronizer; d1/d2 keep the two previous line samples
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_d1 <= 1'b1;
      rxd_d2 <= 1'b1;
    end else begin
      rxd_p0 <= bus.rxd;
      rxd_p1 <= rxd_p0;
      rxd_d1 <= rxd_p1;
      rxd_d2 <= rxd_d1;
    end
  end

  assign at_sample  = (cnt == CNT_W'(HALF + 1));
  assign at_wrap    = (cnt == CNT_W'(CLK_P_BIT - 1));
  assign sample_bit = majority3(rxd_d2, rxd_d1, rxd_p1);

  always_comb begin
    state_d   = state_q;
    start_det = 1'b0;
    idx_clr   = 1'b0;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxd_p1 && bus.enable) begin
          state_d   = START;
          start_det = 1'b1;
          idx_clr   = 1'b1;
        end
      end
      START: begin
        if (at_sample && sample_bit) begin
          state_d = IDLE;
        end else if (at_wrap) begin
          state_d = DATA;
          idx_clr = 1'b1;
        end
      end
      DATA: begin
        if (at_wrap && bit_idx == IDX_W'(N_BITS - 1)) begin
          state_d = (PARITY != 0) ? PARITY_BIT : STOP;
          idx_clr = 1'b1;
        end
      end
      PARITY_BIT: begin
        if (at_wrap) begin
          state_d = STOP;
          idx_clr = 1'b1;
        end
      end
      STOP: begin
        // Leave at the last stop-bit sample so the next start edge is caught early
        if (at_sample && bit_idx == IDX_W'(STOP_BITS - 1)) begin
          state_d = IDLE;
          push    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == IDLE || start_det || at_wrap) cnt <= '0;
      else                                         cnt <= cnt + CNT_W'(1);
      if (idx_clr)      bit_idx <= '0;
      else if (at_wrap) bit_idx <= bit_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == DATA && at_sample) shreg <= {sample_bit, shreg[N_BITS-1:1]};
    if (start_det) begin
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else if (at_sample) begin
      if (state_q == PARITY_BIT) par_err_q <= ((^shreg) ^ sample_bit) != (PARITY == 1);
      if (state_q == STOP && !sample_bit) frm_err_q <= 1'b1;
    end
  end

  assign push_word = {par_err_q, frm_err_q | ~sample_bit, shreg};

  // Word FIFO: a pop frees the slot a same-cycle push into a full FIFO reuses
  assign full  = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign pop   = bus.valid && bus.ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
      if (drop)               overrun_q <= 1'b1;
      else if (bus.err_clear) overrun_q <= 1'b0;
    end
  end

  assign head           = mem[rd_ptr];
  assign bus.valid      = (count != '0);
  assign bus.data       = bus.valid ? head[N_BITS-1:0] : '0;
  assign bus.frame_err  = bus.valid & head[N_BITS];
  assign bus.parity_err = bus.valid & head[N_BITS+1];
  assign bus.overrun    = overrun_q;
  assign bus.fifo_count = count;
endmodule
